// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter: multiply-accumulate, one digit per clock, MSD first.
// Optional `BCD_DIGIT_CHECK_EN adds a digit_err output that flags (and zeroes) results with digits > 9.
module bcd_to_binary_seq #(
  parameter int unsigned BIN_WIDTH  = 32,
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [NUM_DIGITS-1:0][3:0] bcd_in,
  output logic [BIN_WIDTH-1:0]       binary_out,
  output logic                       done,
  output logic                       busy,
  output logic                       overflow
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                       digit_err
`endif
);

  localparam int unsigned ACC_W = BIN_WIDTH + 4;
  localparam int unsigned SR_W  = NUM_DIGITS * 4;
  localparam int unsigned CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_capture;
  logic                 w_finish;
  logic [SR_W-1:0]      r_sr;
  logic [BIN_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic [3:0]           w_msd;
  logic [ACC_W-1:0]     w_step;
  logic                 w_step_ovf;
  logic                 w_last;

  assign w_msd      = r_sr[SR_W-1 -: 4];
  // Step result is 4 bits wider than the result, enough for acc*10 + 15.
  assign w_step     = ACC_W'(r_acc) * ACC_W'(10) + ACC_W'(w_msd);
  assign w_step_ovf = |w_step[ACC_W-1:BIN_WIDTH];
  assign w_last     = (r_cnt == CNT_W'(NUM_DIGITS - 1));

`ifdef BCD_DIGIT_CHECK_EN
  logic w_bad_digit;
  logic r_derr;

  always_comb begin
    w_bad_digit = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[i] > 4'd9) w_bad_digit = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_capture   = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (load) begin
          w_capture   = 1'b1;
          w_state_nxt = S_CONV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; results only move on the finishing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      binary_out <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      r_derr     <= 1'b0;
      digit_err  <= 1'b0;
`endif
    end else begin
      done <= w_finish;
      if (w_capture) begin
        r_sr   <= bcd_in;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
        busy   <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
        r_derr <= w_bad_digit;
`endif
      end else if (r_state == S_CONV) begin
        r_acc <= w_step[BIN_WIDTH-1:0];
        r_sr  <= r_sr << 4;
        r_cnt <= r_cnt + CNT_W'(1);
        r_ovf <= r_ovf | w_step_ovf;
        if (w_finish) begin
          overflow   <= r_ovf | w_step_ovf;
          busy       <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
          digit_err  <= r_derr;
          binary_out <= r_derr ? '0 : w_step[BIN_WIDTH-1:0];
`else
          binary_out <= w_step[BIN_WIDTH-1:0];
`endif
        end
      end
    end
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential packed-BCD to binary converter. It is the inverse of the team's binary-to-BCD converter and sits on the return path: decimal digit fields from display or entry logic are turned back into a binary word. It uses multiply-accumulate, one digit per clock, most significant digit first, with a load/done handshake.

Parameters:
BIN_WIDTH, 32, width of the binary result in bits (must be >= 4).
NUM_DIGITS, 3, number of BCD digits in the input (must be >= 1).

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
load  input  1  start request; sampled on the rising clk edge.
bcd_in  input  [NUM_DIGITS-1:0][3:0]  packed BCD digits; [NUM_DIGITS-1] is the most significant digit.
binary_out  output  BIN_WIDTH  conversion result; held until the next accepted load.
done  output  1  one-cycle pulse when binary_out has been updated.
busy  output  1  high while a conversion is in progress.
overflow  output  1  result exceeded 2^BIN_WIDTH-1; valid with done, held with binary_out.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE.
  - binary_out=0, done=0, busy=0, overflow=0.
  - Accumulator, digit shift register and counter are cleared.
  - Reset mid-conversion aborts it; no done pulse is produced.
- FSM states: IDLE, CONV, DONE.
  - IDLE: load=1 at an edge captures bcd_in into the shift register, sets acc=0, cnt=0, clears the internal overflow flag, sets busy=1, and moves to CONV.
  - CONV: each edge does acc <= acc*10 + msd, shifts the register left by one digit, and increments cnt. The edge that processes digit index 0 (cnt = NUM_DIGITS-1) writes the final value to binary_out and overflow, asserts done, clears busy, and moves to DONE.
  - DONE: lasts one cycle. done=1; next state is IDLE, or CONV if load=1 in this cycle (back-to-back accepted, same capture actions as IDLE).
- Latency: with load sampled at edge k, done is high in the cycle after edge k+NUM_DIGITS, and binary_out updates at that same edge.
- load while busy=1 (CONV) is ignored; bcd_in is not re-sampled.
- bcd_in only needs to be stable at the accepting edge.
- Arithmetic:
  - The accumulator is BIN_WIDTH+4 bits wide internally.
  - If any step result is >= 2^BIN_WIDTH, the overflow flag becomes sticky for that conversion and the accumulator keeps the low BIN_WIDTH bits.
  - binary_out is the final value mod 2^BIN_WIDTH.
- binary_out and overflow do not change outside the done edge or reset.
- Digits greater than 9 are handled as described under Optional Feature.

Optional Feature:
Macro: BCD_DIGIT_CHECK_EN
- Defined:
  - Adds output port digit_err (1 bit, reset 0), updated at the done edge and held like overflow.
  - Any captured digit > 9 sets digit_err=1 for that conversion and forces binary_out=0.
  - Conversion timing is unchanged.
- Undefined:
  - No digit_err port.
  - Digits > 9 enter the arithmetic with their raw value (e.g. digits A,0,0 give 1000).

Test Plan:
1. Reset 20 ns, then load with bcd_in={0,1,1} (default parameters) -> done pulses 3 cycles after the load edge; binary_out=32'h0000000B, overflow=0, busy high for exactly 3 cycles.
2. bcd_in={9,9,9} -> binary_out=999 (0x3E7). Next load with {0,0,0} -> binary_out=0. Both done pulses are exactly one cycle wide.
3. BIN_WIDTH=8, NUM_DIGITS=3, bcd_in={3,0,0} -> binary_out=44 (300 mod 256), overflow=1. Next conversion of {2,5,5} -> 255, overflow=0.
4. Assert load again 1 cycle after an accepted load, with different bcd_in -> ignored; result is that of the first operand. Load asserted in the DONE cycle -> second conversion starts; its done arrives NUM_DIGITS cycles later.
5. Assert rst asynchronously mid-CONV (between clock edges) -> all outputs 0 immediately; no done pulse; a fresh load afterwards converts correctly.
6. With BCD_DIGIT_CHECK_EN, bcd_in={1,A,2} -> digit_err=1, binary_out=0. Without the macro -> binary_out=202, no digit_err port.
